// File: rtl/axis_packet_fifo_if.sv
// AXI4-Stream bundle used by axis_packet_fifo.
// Signals: tvalid/tready handshake, tdata (BUS_WIDTH bytes), tkeep (one bit
// per byte), tlast (end of packet), tuser and tdest sidebands.
// Modports:
//   master - drives the payload and tvalid, samples tready
//   slave  - samples the payload and tvalid, drives tready
interface axis_packet_fifo_if #(
  parameter int BUS_WIDTH  = 2,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1
);
  logic                   tvalid;
  logic                   tready;
  logic [BUS_WIDTH*8-1:0] tdata;
  logic [BUS_WIDTH-1:0]   tkeep;
  logic                   tlast;
  logic [USER_WIDTH-1:0]  tuser;
  logic [DEST_WIDTH-1:0]  tdest;

  modport master (
    output tvalid, tdata, tkeep, tlast, tuser, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast, tuser, tdest,
    output tready
  );
endinterface

// File: rtl/axis_packet_fifo.sv
// Single-clock AXI4-Stream elastic buffer with full sideband
// (tdata/tkeep/tlast/tuser/tdest), first-word fall-through output,
// occupancy count, almost-full/almost-empty flags and an optional
// store-and-forward packet mode.
// Ports:
//   aclk, arst     - clock and synchronous active-high reset
//   s_axis (slave) - write side; tready is registered
//   m_axis (master)- read side; payload is the entry at the read pointer
//   occupancy      - number of stored entries (0..FIFO_DEPTH)
//   almost_full    - occupancy >= ALMOST_FULL_LVL  (registered)
//   almost_empty   - occupancy <= ALMOST_EMPTY_LVL (registered)
// In packet mode the output only presents data once a complete packet
// (tlast) is stored, or when the buffer is full so that packets longer than
// the buffer still drain.
module axis_packet_fifo #(
  parameter int FIFO_DEPTH       = 16,
  parameter int BUS_WIDTH        = 2,
  parameter int USER_WIDTH       = 1,
  parameter int DEST_WIDTH       = 1,
  parameter int PACKET_MODE      = 0,
  parameter int ALMOST_FULL_LVL  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_LVL = 2
) (
  input  logic                        aclk,
  input  logic                        arst,
  axis_packet_fifo_if.slave           s_axis,
  axis_packet_fifo_if.master          m_axis,
  output logic [$clog2(FIFO_DEPTH):0] occupancy,
  output logic                        almost_full,
  output logic                        almost_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam int EW = BUS_WIDTH * 8 + BUS_WIDTH + 1 + USER_WIDTH + DEST_WIDTH;
  // Bit position of tlast inside a stored entry {tdata, tkeep, tlast, tuser, tdest}.
  localparam int LAST_BIT = USER_WIDTH + DEST_WIDTH;

  typedef logic [OW-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);
  localparam cnt_t AF_C    = cnt_t'(ALMOST_FULL_LVL);
  localparam cnt_t AE_C    = cnt_t'(ALMOST_EMPTY_LVL);

  // Writes are held off for one edge after reset release.
  typedef enum logic {
    ST_WAKE,
    ST_RUN
  } state_t;

  state_t        state_q, state_nxt;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  cnt_t          occ_q, occ_nxt;
  cnt_t          pkt_cnt_q, pkt_cnt_nxt;
  logic          ready_q, ready_nxt;
  logic          af_q, ae_q;

  logic          wr_en, rd_en;
  logic          pkt_ok;
  logic [EW-1:0] wr_entry, rd_entry;
  logic          rd_last;

  assign wr_entry = {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tuser, s_axis.tdest};
  assign rd_entry = mem[rd_ptr];
  assign rd_last  = rd_entry[LAST_BIT];

  assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser, m_axis.tdest} = rd_entry;

  // Cut-through presents any stored word; packet mode needs a complete packet,
  // or a full buffer so an oversized packet cannot deadlock.
  assign pkt_ok = (PACKET_MODE == 0) || (pkt_cnt_q != '0) || (occ_q == DEPTH_C);

  // Handshakes are masked during reset so no word moves on the reset edge.
  assign m_axis.tvalid = !arst && (occ_q != '0) && pkt_ok;
  assign s_axis.tready = !arst && ready_q;

  assign wr_en = s_axis.tvalid && s_axis.tready;
  assign rd_en = m_axis.tvalid && m_axis.tready;

  assign occupancy    = occ_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

  always_comb begin
    occ_nxt = occ_q;
    case ({wr_en, rd_en})
      2'b10:   occ_nxt = occ_q + 1'b1;
      2'b01:   occ_nxt = occ_q - 1'b1;
      default: occ_nxt = occ_q;
    endcase
  end

  always_comb begin
    pkt_cnt_nxt = pkt_cnt_q;
    case ({wr_en && s_axis.tlast, rd_en && rd_last})
      2'b10:   pkt_cnt_nxt = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_nxt = pkt_cnt_q - 1'b1;
      default: pkt_cnt_nxt = pkt_cnt_q;
    endcase
  end

  always_comb begin
    state_nxt = state_q;
    ready_nxt = 1'b0;
    case (state_q)
      ST_WAKE: state_nxt = ST_RUN;
      ST_RUN:  ready_nxt = (occ_nxt < DEPTH_C);
      default: state_nxt = ST_WAKE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q   <= ST_WAKE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ_q     <= '0;
      pkt_cnt_q <= '0;
      ready_q   <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
    end else begin
      state_q   <= state_nxt;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      occ_q     <= occ_nxt;
      pkt_cnt_q <= pkt_cnt_nxt;
      ready_q   <= ready_nxt;
      af_q      <= (occ_nxt >= AF_C);
      ae_q      <= (occ_nxt <= AE_C);
    end
  end

  // Storage is not reset; pointers alone define valid contents.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: one cut-through instance (index 0) and one
// packet-mode instance (index 1), each followed by a queue-based reference model.
module tb_axis_packet_fifo;

  localparam int DEPTH = 16;
  localparam int BW    = 2;
  localparam int UW    = 2;
  localparam int DW    = 3;
  localparam int AFL   = 14;
  localparam int AEL   = 2;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic        last;
    logic [1:0]  user;
    logic [2:0]  dest;
  } beat_t;

  typedef struct {
    logic  v;
    beat_t b;
    logic  mr;
    logic  ev;
    int    occ;
    logic  ae;
    beat_t eb;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  beat_t      drv_beat   [2];
  logic       drv_valid  [2];
  logic       drv_ready  [2];
  beat_t      obs_beat   [2];
  logic       obs_tvalid [2];
  logic       obs_tready [2];
  logic       obs_af     [2];
  logic       obs_ae     [2];
  logic [4:0] obs_occ    [2];
  beat_t      rx1[$];

  always #5 clk = ~clk;

  axis_packet_fifo_if #(.BUS_WIDTH(BW), .USER_WIDTH(UW), .DEST_WIDTH(DW)) s_ct ();
  axis_packet_fifo_if #(.BUS_WIDTH(BW), .USER_WIDTH(UW), .DEST_WIDTH(DW)) m_ct ();
  axis_packet_fifo_if #(.BUS_WIDTH(BW), .USER_WIDTH(UW), .DEST_WIDTH(DW)) s_pk ();
  axis_packet_fifo_if #(.BUS_WIDTH(BW), .USER_WIDTH(UW), .DEST_WIDTH(DW)) m_pk ();

  assign s_ct.tvalid = drv_valid[0];
  assign s_ct.tdata  = drv_beat[0].data;
  assign s_ct.tkeep  = drv_beat[0].keep;
  assign s_ct.tlast  = drv_beat[0].last;
  assign s_ct.tuser  = drv_beat[0].user;
  assign s_ct.tdest  = drv_beat[0].dest;
  assign m_ct.tready = drv_ready[0];
  assign obs_tvalid[0] = m_ct.tvalid;
  assign obs_tready[0] = s_ct.tready;
  assign obs_beat[0]   = {m_ct.tdata, m_ct.tkeep, m_ct.tlast, m_ct.tuser, m_ct.tdest};

  assign s_pk.tvalid = drv_valid[1];
  assign s_pk.tdata  = drv_beat[1].data;
  assign s_pk.tkeep  = drv_beat[1].keep;
  assign s_pk.tlast  = drv_beat[1].last;
  assign s_pk.tuser  = drv_beat[1].user;
  assign s_pk.tdest  = drv_beat[1].dest;
  assign m_pk.tready = drv_ready[1];
  assign obs_tvalid[1] = m_pk.tvalid;
  assign obs_tready[1] = s_pk.tready;
  assign obs_beat[1]   = {m_pk.tdata, m_pk.tkeep, m_pk.tlast, m_pk.tuser, m_pk.tdest};

  axis_packet_fifo #(
    .FIFO_DEPTH(DEPTH), .BUS_WIDTH(BW), .USER_WIDTH(UW), .DEST_WIDTH(DW),
    .PACKET_MODE(0), .ALMOST_FULL_LVL(AFL), .ALMOST_EMPTY_LVL(AEL)
  ) u_ct (
    .aclk(clk), .arst(rst), .s_axis(s_ct), .m_axis(m_ct),
    .occupancy(obs_occ[0]), .almost_full(obs_af[0]), .almost_empty(obs_ae[0])
  );

  axis_packet_fifo #(
    .FIFO_DEPTH(DEPTH), .BUS_WIDTH(BW), .USER_WIDTH(UW), .DEST_WIDTH(DW),
    .PACKET_MODE(1), .ALMOST_FULL_LVL(AFL), .ALMOST_EMPTY_LVL(AEL)
  ) u_pk (
    .aclk(clk), .arst(rst), .s_axis(s_pk), .m_axis(m_pk),
    .occupancy(obs_occ[1]), .almost_full(obs_af[1]), .almost_empty(obs_ae[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [15:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.keep = d[1:0];
    b.last = l;
    b.user = d[3:2];
    b.dest = d[6:4];
    return b;
  endfunction

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int g, input logic v, input beat_t b);
    drv_valid[g] = v;
    drv_beat[g]  = b;
  endtask

  // Reads n words base, base+1, ... with tlast on the final one, then expects empty.
  task automatic drain_check(input int g, input int base, input int n);
    drv_valid[g] = 1'b0;
    drv_ready[g] = 1'b1;
    for (int j = 0; j < n; j++) begin
      check($sformatf("drain%0d_tvalid", g), obs_tvalid[g], 1);
      check($sformatf("drain%0d_beat", g), obs_beat[g], mk(16'(base + j), j == n - 1));
      clk1();
    end
    check($sformatf("drain%0d_occ_end", g), obs_occ[g], 0);
    check($sformatf("drain%0d_tvalid_end", g), obs_tvalid[g], 0);
  endtask

  // Reference model: a queue of stored beats. Packets stored = tlast beats in queue.
  for (genvar g = 0; g < 2; g++) begin : g_ref
    beat_t q[$];
    bit    rdy  = 1'b0;
    bit    init = 1'b0;

    always @(posedge clk) begin
      int nl;
      bit ev, er, wr, rd;
      nl = 0;
      foreach (q[k]) if (q[k].last) nl++;
      ev = !rst && q.size() != 0 && (g == 0 || nl != 0 || q.size() == DEPTH);
      er = !rst && rdy;
      wr = drv_valid[g] && er;
      rd = ev && drv_ready[g];
      if (rst) begin
        q.delete();
        rdy  = 1'b0;
        init = 1'b0;
      end else begin
        if (rd) void'(q.pop_front());
        if (wr) q.push_back(drv_beat[g]);
        rdy  = init && q.size() < DEPTH;
        init = 1'b1;
      end
    end

    always @(negedge clk) begin
      int nl;
      bit ev;
      if (chk_en) begin
        nl = 0;
        foreach (q[k]) if (q[k].last) nl++;
        ev = !rst && q.size() != 0 && (g == 0 || nl != 0 || q.size() == DEPTH);
        check($sformatf("model%0d_tvalid", g), obs_tvalid[g], ev);
        check($sformatf("model%0d_tready", g), obs_tready[g], !rst && rdy);
        check($sformatf("model%0d_occ", g), obs_occ[g], q.size());
        check($sformatf("model%0d_af", g), obs_af[g], q.size() >= AFL);
        check($sformatf("model%0d_ae", g), obs_ae[g], q.size() <= AEL);
        if (ev) check($sformatf("model%0d_beat", g), obs_beat[g], q[0]);
      end
    end
  end

  // Collect words leaving the packet-mode instance (read happens on the next edge).
  always @(negedge clk) begin
    if (!rst && obs_tvalid[1] && drv_ready[1]) rx1.push_back(obs_beat[1]);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    vec_t r;
    int   first_occ;
    int   budget;
    bit   acc;

    // Table: {valid, data, last, m_ready, exp tvalid, exp occ, exp ae, exp data, exp last}
    begin
      int t[9][9] = '{
        '{1, 'hA001, 0, 0, 1, 1, 1, 'hA001, 0},
        '{1, 'hA002, 0, 0, 1, 2, 1, 'hA001, 0},
        '{1, 'hA003, 0, 1, 1, 2, 1, 'hA002, 0},
        '{1, 'hA004, 1, 0, 1, 3, 0, 'hA002, 0},
        '{0, 'h0000, 0, 1, 1, 2, 1, 'hA003, 0},
        '{0, 'h0000, 0, 1, 1, 1, 1, 'hA004, 1},
        '{0, 'h0000, 0, 1, 0, 0, 1, 'h0000, 0},
        '{1, 'hA005, 1, 1, 1, 1, 1, 'hA005, 1},
        '{0, 'h0000, 0, 1, 0, 0, 1, 'h0000, 0}
      };
      for (int i = 0; i < 9; i++) begin
        r.v   = t[i][0] != 0;
        r.b   = mk(16'(t[i][1]), t[i][2] != 0);
        r.mr  = t[i][3] != 0;
        r.ev  = t[i][4] != 0;
        r.occ = t[i][5];
        r.ae  = t[i][6] != 0;
        r.eb  = mk(16'(t[i][7]), t[i][8] != 0);
        tbl.push_back(r);
      end
    end

    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      drive(g, 1'b0, '0);
      drv_ready[g] = 1'b0;
    end

    // Reset and release
    clk1();
    chk_en = 1'b1;
    repeat (3) clk1();
    check("rst_tvalid", obs_tvalid[0], 0);
    check("rst_tready", obs_tready[0], 0);
    check("rst_occ", obs_occ[0], 0);
    check("rst_ae", obs_ae[0], 1);
    check("rst_af", obs_af[0], 0);
    rst = 1'b0;
    clk1();
    check("rel1_tready", obs_tready[0], 0);
    check("rel1_tvalid", obs_tvalid[0], 0);
    clk1();
    check("rel2_tready", obs_tready[0], 1);
    check("rel2_occ", obs_occ[0], 0);
    check("rel2_ae", obs_ae[0], 1);

    // Table-driven cut-through sequence
    foreach (tbl[i]) begin
      drive(0, tbl[i].v, tbl[i].b);
      drv_ready[0] = tbl[i].mr;
      clk1();
      check($sformatf("vec%0d_tvalid", i), obs_tvalid[0], tbl[i].ev);
      check($sformatf("vec%0d_occ", i), obs_occ[0], tbl[i].occ);
      check($sformatf("vec%0d_ae", i), obs_ae[0], tbl[i].ae);
      check($sformatf("vec%0d_af", i), obs_af[0], 0);
      check($sformatf("vec%0d_tready", i), obs_tready[0], 1);
      if (tbl[i].ev) check($sformatf("vec%0d_beat", i), obs_beat[0], tbl[i].eb);
    end

    // Fill to full, then drain
    drv_ready[0] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1'b1, mk(16'(i), i == DEPTH - 1));
      clk1();
      check("fill_occ", obs_occ[0], i + 1);
      check("fill_af", obs_af[0], (i + 1) >= AFL);
      check("fill_tready", obs_tready[0], (i + 1) < DEPTH);
    end
    drive(0, 1'b1, mk(16'h0010, 1'b0));
    clk1();
    check("full_hold_occ", obs_occ[0], DEPTH);
    check("full_hold_tready", obs_tready[0], 0);
    drv_valid[0] = 1'b0;
    drv_ready[0] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drainf_tvalid", obs_tvalid[0], 1);
      check("drainf_beat", obs_beat[0], mk(16'(i), i == DEPTH - 1));
      clk1();
      check("drainf_occ", obs_occ[0], DEPTH - 1 - i);
      if (i == 0) check("full_read_tready", obs_tready[0], 1);
    end
    check("drainf_tvalid_end", obs_tvalid[0], 0);
    check("drainf_ae_end", obs_ae[0], 1);

    // Streaming, one word per cycle
    for (int i = 0; i < 100; i++) begin
      drive(0, 1'b1, mk(16'(16'h0100 + i), 1'b0));
      clk1();
      check("stream_tvalid", obs_tvalid[0], 1);
      check("stream_occ", obs_occ[0], 1);
      check("stream_beat", obs_beat[0], mk(16'(16'h0100 + i), 1'b0));
    end
    drv_valid[0] = 1'b0;
    clk1();
    check("stream_end_occ", obs_occ[0], 0);

    // Reset with 7 words stored
    drv_ready[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(0, 1'b1, mk(16'(16'h0200 + i), 1'b0));
      clk1();
    end
    check("mid_pre_occ", obs_occ[0], 7);
    drv_valid[0] = 1'b0;
    rst = 1'b1;
    clk1();
    check("mid_rst_occ", obs_occ[0], 0);
    check("mid_rst_tvalid", obs_tvalid[0], 0);
    rst = 1'b0;
    clk1();
    clk1();
    check("mid_rel_tready", obs_tready[0], 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, mk(16'(16'h0300 + i), i == 3));
      clk1();
    end
    check("mid_post_occ", obs_occ[0], 4);
    drain_check(0, 'h0300, 4);

    // Packet mode: 5-word packet held until tlast stored
    drv_ready[1] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      drive(1, 1'b1, mk(16'(16'h0400 + j), j == 4));
      clk1();
      check("pkt5_tvalid", obs_tvalid[1], j == 4);
      check("pkt5_occ", obs_occ[1], j + 1);
    end
    drain_check(1, 'h0400, 5);

    // Packet mode: 20-word packet through a 16-entry buffer
    rx1.delete();
    first_occ = -1;
    for (int i = 0; i < 20; i++) begin
      drive(1, 1'b1, mk(16'(16'h0500 + i), i == 19));
      budget = 0;
      do begin
        acc = obs_tready[1];
        clk1();
        if (obs_tvalid[1] && first_occ < 0) first_occ = int'(obs_occ[1]);
        budget++;
      end while (!acc && budget < 50);
      if (!acc) check("ovf_write_timeout", 0, 1);
    end
    drv_valid[1] = 1'b0;
    for (int k = 0; k < 100 && rx1.size() < 20; k++) clk1();
    clk1();
    check("ovf_first_valid_occ", first_occ, DEPTH);
    check("ovf_rx_count", rx1.size(), 20);
    for (int i = 0; i < 20 && i < rx1.size(); i++)
      check("ovf_rx_beat", rx1[i], mk(16'(16'h0500 + i), i == 19));
    check("ovf_end_occ", obs_occ[1], 0);
    check("ovf_end_tvalid", obs_tvalid[1], 0);

    // Randomized traffic against the reference models
    for (int c = 0; c < 1500; c++) begin
      for (int g = 0; g < 2; g++) begin
        beat_t b;
        b = beat_t'(24'($urandom()));
        b.last = ($urandom_range(0, 5) == 0);
        drive(g, $urandom_range(0, 3) != 0, b);
        drv_ready[g] = (c < 750) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      end
      rst = ($urandom_range(0, 399) == 0);
      clk1();
    end
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      drv_valid[g] = 1'b0;
      drv_ready[g] = 1'b1;
    end
    repeat (40) clk1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
